// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that lets N_REQ word-level requesters share one UART byte
// transmitter, sending each captured word LSB byte first over a start/done handshake.
module uart_tx_word_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int IDW        = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        tx_start,
  output logic [7:0]                  tx_byte,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic                        word_done,
  output logic [IDW-1:0]              word_done_id
);

  localparam int CNTW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(WORD_BYTES - 1);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(N_REQ - 1);

  logic [1:0]            state_reg;
  logic [DATA_WIDTH-1:0] shreg_reg;
  logic [CNTW-1:0]       byte_cnt_reg;
  logic [IDW-1:0]        last_grant_reg;
  logic [IDW-1:0]        grant_id_reg;
  logic                  busy_reg;
  logic                  tx_start_reg;
  logic [7:0]            tx_byte_reg;
  logic                  word_done_reg;
  logic [IDW-1:0]        word_done_id_reg;

  logic [DATA_WIDTH-1:0] req_word [N_REQ];
  logic                  pick_found;
  logic [IDW-1:0]        pick_id;
  logic [DATA_WIDTH-1:0] pick_word;
  logic                  accept;
  int                    cand;
  logic [IDW-1:0]        cand_id;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan downward so the candidate closest after last_grant is written last and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_word  = '0;
    cand       = 0;
    cand_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = int'(last_grant_reg) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_id = IDW'(cand);
      if (req_valid[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
        pick_word  = req_word[cand_id];
      end
    end
  end

  assign accept = (state_reg == ST_IDLE) && pick_found && !rst;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (pick_id == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      shreg_reg        <= '0;
      byte_cnt_reg     <= '0;
      last_grant_reg   <= LAST_ID;
      grant_id_reg     <= '0;
      busy_reg         <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_byte_reg      <= '0;
      word_done_reg    <= 1'b0;
      word_done_id_reg <= '0;
    end else begin
      tx_start_reg  <= 1'b0;
      word_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            shreg_reg    <= pick_word;
            grant_id_reg <= pick_id;
            byte_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            tx_byte_reg  <= shreg_reg[7:0];
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // word_done is registered so it is high exactly during the FINISH cycle.
          if (tx_done) begin
            shreg_reg    <= shreg_reg >> 8;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == LAST_BYTE) begin
              word_done_reg    <= 1'b1;
              word_done_id_reg <= grant_id_reg;
              state_reg        <= ST_FINISH;
            end else begin
              state_reg <= ST_SEND;
            end
          end
        end
        default: begin
          last_grant_reg <= grant_id_reg;
          busy_reg       <= 1'b0;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start     = tx_start_reg;
  assign tx_byte      = tx_byte_reg;
  assign grant_id     = grant_id_reg;
  assign busy         = busy_reg;
  assign word_done    = word_done_reg;
  assign word_done_id = word_done_id_reg;

endmodule

// File: doc/uart_tx_word_arbiter.md
Name: uart_tx_word_arbiter

Overview:
Shares one UART byte transmitter between N_REQ word-level requesters, e.g. the CPU MMIO port and the debug/trace port.
- Arbitrates round-robin and captures the winning DATA_WIDTH-bit word.
- Sends the word LSB-byte-first as WORD_BYTES byte transfers using a start/done handshake with the byte transmitter.
- Signals completion per word.
- Sits between the requesters and the UART TX engine.

Parameters:
N_REQ, 2, number of requesters (>=2)
DATA_WIDTH, 32, word width in bits; must equal 8*WORD_BYTES
WORD_BYTES, 4, bytes per word
IDW, $clog2(N_REQ), width of requester id fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester word valid
req_data  in  N_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  N_REQ  one-hot accept pulse; word taken when valid&ready
tx_start  out  1  one-cycle start pulse to byte transmitter
tx_byte  out  8  byte to send; valid while tx_start=1
tx_busy  in  1  byte transmitter busy
tx_done  in  1  one-cycle pulse when the byte's stop bit completes
grant_id  out  IDW  id of the requester currently being served
busy  out  1  high from word accept through FINISH
word_done  out  1  one-cycle pulse when the last byte of a word completes
word_done_id  out  IDW  requester id for word_done

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - State goes to IDLE.
  - All outputs are 0.
  - Shift register and byte_cnt are cleared.
  - last_grant is set to N_REQ-1, so requester 0 has first priority.
  - Reset mid-word discards the word; no word_done is issued.
- FSM states: IDLE, SEND, WAIT, FINISH.
- IDLE:
  - If any req_valid is set, choose g as the first set bit scanning from (last_grant+1) mod N_REQ upward, with wrap.
  - Same cycle: req_ready[g]=1 combinationally; shreg<=req_data[g]; grant_id<=g; byte_cnt<=0; busy<=1; go to SEND.
  - req_ready is never asserted outside IDLE.
  - At most one req_ready bit is high per cycle.
- SEND:
  - If tx_busy=1, hold with tx_start=0.
  - Else assert tx_start=1 for exactly one cycle with tx_byte=shreg[7:0], then go to WAIT.
  - First tx_start comes no earlier than 1 cycle after accept.
- WAIT:
  - On tx_done: shreg shifts right by 8 and byte_cnt increments.
  - If byte_cnt==WORD_BYTES-1, go to FINISH; else go to SEND.
  - tx_start=0 throughout.
- FINISH (one cycle):
  - word_done=1, word_done_id=grant_id; last_grant<=grant_id; busy<=0; go to IDLE.
  - A new word can be accepted in the IDLE cycle directly after FINISH.
- tx_done in IDLE, SEND or FINISH is ignored: no count change, no state change.
- tx_byte holds its last value when tx_start=0; only the value during tx_start is meaningful.
- Round-robin guarantee: with all requesters continuously valid, grants cycle 0,1,…,N_REQ-1,0,…
- Starvation-free: a valid requester is served within N_REQ words.
- Requesters may drop req_valid without being served (no lock-in).
- Data is captured at accept; later changes to req_data do not affect the word in flight.

Test Plan:
1. Single word: req_valid=01, req_data[0]=0xDEADBEEF; tx_done 20 cycles after each start.
   -> req_ready=01 for 1 cycle; tx_byte sequence EF, BE, AD, DE with exactly 4 tx_start pulses; word_done=1 with id 0 once; busy low after FINISH.
2. Contention: both requesters valid continuously from reset, req_data[0]=0x11111111, req_data[1]=0x22222222.
   -> grant order 0,1,0,1; byte streams 11×4, 22×4, 11×4, 22×4.
3. Busy stall: hold tx_busy=1 for 10 cycles on entering SEND.
   -> tx_start stays 0 for those 10 cycles, then pulses once when tx_busy falls; byte order unchanged.
4. Spurious done: pulse tx_done in IDLE and in SEND.
   -> no state/byte_cnt change; a subsequent word still emits exactly 4 bytes.
5. Reset mid-word: rst=1 one cycle after the 2nd tx_done of 0x01020304.
   -> all outputs 0 next cycle, no word_done; a new word 0xA0B0C0D0 afterwards starts at D0 and is granted to requester 0 if both are valid.
6. N_REQ=3, only req_valid[2] set, word 0x00FF00FF.
   -> grant_id=2, bytes FF, 00, FF, 00, word_done_id=2.
